// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the configuration-chain loader.
//   state_t : controller FSM states
//   cnt_w   : width of a counter that must hold 0..max_val without wrapping
package config_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/config_shift_unit.sv
// Word-to-bit serialiser feeding the chain head, LSB first.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_load          capture i_word_in (takes priority over i_shift)
//   i_flush         discard any unshifted bits (takes priority over i_load)
//   i_shift         consume the current bit
//   i_word_in       bitstream word
//   o_bit_out       current bit; 0 whenever the unit is empty
//   o_empty         no bit available this cycle
//   o_empty_nxt     o_empty as it will be next cycle
//   o_last_nxt      next cycle's bit is the last of its word
module config_shift_unit
  import config_chain_pkg::*;
#(
  parameter int WORD_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word_in,
  output logic              o_bit_out,
  output logic              o_empty,
  output logic              o_empty_nxt,
  output logic              o_last_nxt
);

  localparam int BIT_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] r_sreg, w_sreg_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;  // bits remaining, counts down
  logic              r_valid;

  always_comb begin
    w_sreg_nxt    = r_sreg;
    w_bit_cnt_nxt = r_bit_cnt;
    if (i_flush) begin
      w_sreg_nxt    = '0;
      w_bit_cnt_nxt = '0;
    end else if (i_load) begin
      w_sreg_nxt    = i_word_in;
      w_bit_cnt_nxt = BIT_W'(WORD_W);
    end else if (i_shift && r_valid) begin
      // Zero fill keeps o_bit_out low once the word has drained.
      w_sreg_nxt    = r_sreg >> 1;
      w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_sreg    <= w_sreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_valid   <= (w_bit_cnt_nxt != '0);
    end
  end

  assign o_bit_out   = r_sreg[0];
  assign o_empty     = ~r_valid;
  assign o_empty_nxt = (w_bit_cnt_nxt == '0);
  assign o_last_nxt  = (w_bit_cnt_nxt == BIT_W'(1));

endmodule

// File: rtl/config_chain_ctrl.sv
// Loads a serial configuration chain of static_dff cells: clears the chain
// through its reset, then streams CHAIN_LEN bits in (LSB of each word first)
// and pulses done.
//
// state | meaning
// IDLE  | waiting for start, chain reset released
// CLEAR | chain reset held low for CLR_CYC cycles
// LOAD  | accepting words and shifting bits into the chain
// DONE  | one-cycle done pulse, chain contents retained
//
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_start           begin a load (sampled in IDLE only)
//   i_word_valid      bitstream word available
//   i_word_data       bitstream word
//   o_word_ready      word accepted on this cycle when valid
//   o_sc_head         serial data to the first chain flop
//   o_sc_en           chain shift enable
//   o_sc_reset_n      chain flop reset, active-low
//   o_busy            high in CLEAR and LOAD
//   o_done            one-cycle pulse at end of load
module config_chain_ctrl
  import config_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4,
  parameter int CLR_CYC   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_word_valid,
  input  logic [WORD_W-1:0] i_word_data,
  output logic              o_word_ready,
  output logic              o_sc_head,
  output logic              o_sc_en,
  output logic              o_sc_reset_n,
  output logic              o_busy,
  output logic              o_done
);

  localparam int TOT_W = cnt_w(CHAIN_LEN);
  localparam int CLR_W = cnt_w(CLR_CYC);

  state_t           r_state, w_state_nxt;
  logic [TOT_W-1:0] r_total, w_total_nxt, w_total_inc;
  logic [CLR_W-1:0] r_clr_cnt, w_clr_nxt;
  logic             w_load, w_shift, w_flush;
  logic             w_bit_out, w_empty, w_empty_nxt, w_last_nxt;
  logic             w_ready_nxt;
  logic             r_word_ready, r_sc_reset_n, r_busy, r_done;

  config_shift_unit #(.WORD_W(WORD_W)) u_shift (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_flush     (w_flush),
    .i_shift     (w_shift),
    .i_word_in   (i_word_data),
    .o_bit_out   (w_bit_out),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt),
    .o_last_nxt  (w_last_nxt)
  );

  assign w_total_inc = r_total + TOT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    w_total_nxt = r_total;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = CLEAR;
          w_clr_nxt   = CLR_W'(CLR_CYC - 1);
          w_total_nxt = '0;
        end
      end
      CLEAR: begin
        if (r_clr_cnt == '0) w_state_nxt = LOAD;
        else                 w_clr_nxt   = r_clr_cnt - CLR_W'(1);
      end
      LOAD: begin
        w_load  = i_word_valid & r_word_ready;
        w_shift = ~w_empty;
        if (w_shift) begin
          w_total_nxt = w_total_inc;
          if (w_total_inc == TOT_W'(CHAIN_LEN)) begin
            // Chain full: drop the tail of a partial last word.
            w_state_nxt = DONE;
            w_flush     = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is registered, so it is computed from next-cycle values: take a word
  // when the serialiser will be empty, or will be on its last bit and the chain
  // still needs more bits after that one.
  assign w_ready_nxt = (w_state_nxt == LOAD) &&
                       (w_empty_nxt ||
                        (w_last_nxt && (w_total_nxt < TOT_W'(CHAIN_LEN - 1))));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_total      <= '0;
      r_clr_cnt    <= '0;
      r_word_ready <= 1'b0;
      r_sc_reset_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_total      <= w_total_nxt;
      r_clr_cnt    <= w_clr_nxt;
      r_word_ready <= w_ready_nxt;
      r_sc_reset_n <= (w_state_nxt != CLEAR);
      r_busy       <= (w_state_nxt == CLEAR) || (w_state_nxt == LOAD);
      r_done       <= (w_state_nxt == DONE);
    end
  end

  assign o_word_ready = r_word_ready;
  assign o_sc_head    = w_bit_out;
  assign o_sc_en      = ~w_empty;
  assign o_sc_reset_n = r_sc_reset_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_config_chain_ctrl.sv
module tb_config_chain_ctrl;

  localparam int CHAIN_LEN = 10;
  localparam int WORD_W    = 4;
  localparam int CLR_CYC   = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              valid = 1'b0;
  logic [WORD_W-1:0] data  = '0;
  logic              ready, head, en, scrn, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [WORD_W-1:0] wq [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  config_chain_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CLR_CYC(CLR_CYC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_word_valid (valid),
    .i_word_data  (data),
    .o_word_ready (ready),
    .o_sc_head    (head),
    .o_sc_en      (en),
    .o_sc_reset_n (scrn),
    .o_busy       (busy),
    .o_done       (done)
  );

  // The fabric chain: CHAIN_LEN static_dff cells with shared enable and reset.
  logic [CHAIN_LEN-1:0] chain;
  always @(posedge clk or negedge scrn) begin
    if (!scrn) chain <= '0;
    else if (en) chain <= {chain[CHAIN_LEN-2:0], head};
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase (0 idle, 1 clear, 2 load, 3 done), a queue of
  // accepted-but-unshifted bits and a count of bits delivered to the chain.
  int                   m_phase   = 0;
  int                   m_clr     = 0;
  int                   m_shifted = 0;
  bit                   m_scrn    = 1'b0;
  bit                   m_pend[$];
  logic [CHAIN_LEN-1:0] m_chain   = '0;

  function automatic bit m_ready_f();
    return (m_phase == 2) &&
           ((m_pend.size() == 0) || (m_pend.size() == 1 && m_shifted + 1 < CHAIN_LEN));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy;
    if (!rst_n) begin
      m_phase   = 0;
      m_clr     = 0;
      m_shifted = 0;
      m_scrn    = 1'b0;
      m_pend.delete();
    end else begin
      rdy = m_ready_f();
      case (m_phase)
        0: if (start) begin
             m_phase   = 1;
             m_clr     = CLR_CYC;
             m_shifted = 0;
             m_chain   = '0;
           end
        1: begin
             m_clr--;
             if (m_clr == 0) m_phase = 2;
           end
        2: begin
             if (m_pend.size() > 0) begin
               m_chain = {m_chain[CHAIN_LEN-2:0], m_pend.pop_front()};
               m_shifted++;
             end
             if (m_shifted == CHAIN_LEN) begin
               m_phase = 3;
               m_pend.delete();
             end else if (valid && rdy) begin
               for (int b = 0; b < WORD_W; b++) m_pend.push_back(data[b]);
             end
           end
        default: m_phase = 0;
      endcase
      m_scrn = (m_phase != 1);
    end
  end

  always @(negedge clk) begin : compare
    bit e_en;
    e_en = (m_phase == 2) && (m_pend.size() > 0);
    chk1("ready", ready, m_ready_f());
    chk1("sc_en", en, e_en);
    if (e_en) chk1("sc_head", head, m_pend[0]);
    chk1("sc_reset_n", scrn, m_scrn);
    chk1("busy", busy, (m_phase == 1) || (m_phase == 2));
    chk1("done", done, m_phase == 3);
    if (m_phase == 3) chkv("chain", 32'(chain), 32'(m_chain));
  end

  // One load: start pulse, then drive words until done (or abort by reset).
  task automatic do_load(input int gap_len, input int abort_bits, input bit rnd,
                         input bit extra, output int lat, output logic [9:0] hseq);
    int idx = 0, shifted = 0, gap_left = 0, c0;
    bit armed = 1'b0, fin = 1'b0;
    lat  = -1;
    hseq = '0;
    @(posedge clk); #1;
    start = 1'b1;
    valid = 1'b0;
    c0    = cyc;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_bits > 0 && shifted == abort_bits) begin
        rst_n = 1'b0;
        #1;
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_sc_en", en, 1'b0);
        chk1("rst_sc_head", head, 1'b0);
        chk1("rst_sc_reset_n", scrn, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 1'b0;
        fin   = 1'b1;
        lat   = 0;
      end else if (done) begin
        lat   = cyc - c0;
        valid = 1'b0;
        fin   = 1'b1;
        chk1("done_ready", ready, 1'b0);
        chk1("done_sc_en", en, 1'b0);
        if (extra) start = 1'b1;
      end else begin
        if (extra) chk1("busy_held", busy, 1'b1);
        if (extra && k == 8) start = 1'b1;
        if (en) begin
          hseq = {hseq[8:0], head};
          shifted++;
        end
        if (gap_left > 0) begin
          valid = 1'b0;
          gap_left--;
        end else if (armed && ready) begin
          valid    = 1'b0;
          gap_left = gap_len - 1;
          armed    = 1'b0;
        end else if (rnd) begin
          valid = ($urandom_range(0, 3) != 0);
          data  = WORD_W'($urandom_range(0, 15));
        end else if (idx < 3) begin
          valid = 1'b1;
          data  = wq[idx];
          if (ready) begin
            idx++;
            if (idx == 1 && gap_len > 0) armed = 1'b1;
          end
        end else begin
          valid = 1'b0;
        end
      end
    end
    chk1("load_finished", fin, 1'b1);
    if (abort_bits == 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk1("single_done", done, 1'b0);
      chk1("idle_after_busy", busy, 1'b0);
      chk1("idle_after_scrn", scrn, 1'b1);
    end
  endtask

  initial begin : main
    logic [9:0] hs;
    int         lat;
    int         ab;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release
    repeat (6) begin @(posedge clk); #1; end
    chk1("idle_scrn", scrn, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ready", ready, 1'b0);
    chk1("idle_sc_en", en, 1'b0);

    // Back-to-back words A,5,3
    wq = '{4'hA, 4'h5, 4'h3};
    do_load(0, 0, 1'b0, 1'b0, lat, hs);
    chkv("t2_latency", 32'(lat), 32'd14);
    chkv("t2_head_seq", 32'(hs), 32'(10'b0101101011));
    chkv("t2_chain", 32'(chain), 32'(10'b0101101011));

    // Five-cycle valid gap after word 1
    do_load(5, 0, 1'b0, 1'b0, lat, hs);
    chkv("t3_latency", 32'(lat), 32'd19);
    chkv("t3_head_seq", 32'(hs), 32'(10'b0101101011));

    // Extra start pulses mid-LOAD and in DONE
    do_load(0, 0, 1'b0, 1'b1, lat, hs);
    chkv("t4_latency", 32'(lat), 32'd14);

    // Reset after six bits, then a clean reload
    do_load(0, 6, 1'b0, 1'b0, lat, hs);
    chkv("t5_chain_cleared", 32'(chain), 32'd0);
    do_load(0, 0, 1'b0, 1'b0, lat, hs);
    chkv("t5_latency", 32'(lat), 32'd14);
    chkv("t5_chain", 32'(chain), 32'(10'b0101101011));

    // Partial last word F: only two of its bits reach the chain
    wq = '{4'hA, 4'h5, 4'hF};
    do_load(0, 0, 1'b0, 1'b0, lat, hs);
    chkv("t6_latency", 32'(lat), 32'd14);
    chkv("t6_chain", 32'(chain), 32'(10'b0101101011));

    // Randomised loads with stalls, stray starts and occasional aborts
    repeat (25) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 0;
      do_load(0, ab, 1'b1, 1'($urandom_range(0, 1)), lat, hs);
      if (ab == 0) chk1("rnd_latency_min", lat >= 14, 1'b1);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
